// File: rtl/sdes_crypt_core.sv
// sdes_crypt_core: iterative S-DES block encrypt/decrypt data path (IP, fk(Ka), SW, fk(Kb), IP^-1)
// Ports: i_clk, i_rst_n (async active-low); input block i_valid/o_ready/i_mode/i_data/i_k1/i_k2;
//        result o_valid/i_ready/o_data; o_blk_cnt (output handshake count) when SDES_BLK_CNT_EN is defined.
// SBOX_REG=1 registers the P4 output so each fk round takes two cycles.
module sdes_crypt_core #(
  parameter int SBOX_REG = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mode,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_k1,
  input  logic [7:0]  i_k2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_data
`ifdef SDES_BLK_CNT_EN
  ,
  output logic [15:0] o_blk_cnt
`endif
);
  localparam logic [2:0] IDLE = 3'd0, R1 = 3'd1, R1S = 3'd2, R2 = 3'd3, R2S = 3'd4, DONE = 3'd5;
  localparam logic [2:0] R1_END = (SBOX_REG != 0) ? R1S : R1;
  localparam logic [2:0] R2_END = (SBOX_REG != 0) ? R2S : R2;
  // S-box tables: entry {row,col} occupies bits [2*idx+1 : 2*idx]
  localparam logic [31:0] S0_TAB = 32'hB7D81BB1;
  localparam logic [31:0] S1_TAB = 32'hC613D2E4;
  function automatic logic [1:0] sbox(input logic [31:0] t, input logic [3:0] n);
    return t[{n[3], n[0], n[2], n[1], 1'b0} +: 2];
  endfunction
  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction
  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction
  logic [2:0] r_state, w_next;
  logic [7:0] r_blk, r_ka, r_kb, r_data;
  logic [3:0] r_p4;
  logic       r_valid;
  logic [7:0] w_ep;
  logic [3:0] w_p4, w_f, w_l;
  logic [1:0] w_s0, w_s1;
  logic       w_acc, w_out_hs;
  assign o_ready  = i_rst_n & (r_state == IDLE | (r_state == DONE & i_ready));
  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign w_acc    = i_valid & o_ready;
  assign w_out_hs = r_valid & i_ready;
  assign w_ep = {r_blk[0], r_blk[3], r_blk[2], r_blk[1], r_blk[2], r_blk[1], r_blk[0], r_blk[3]}
              ^ ((r_state == R1 || r_state == R1S) ? r_ka : r_kb);
  assign w_s0 = sbox(S0_TAB, w_ep[7:4]);
  assign w_s1 = sbox(S1_TAB, w_ep[3:0]);
  assign w_p4 = {w_s0[0], w_s1[0], w_s1[1], w_s0[1]};
  assign w_f  = (SBOX_REG != 0) ? r_p4 : w_p4;
  assign w_l  = r_blk[7:4] ^ w_f;
  always_comb begin
    case (r_state)
      IDLE:    w_next = w_acc ? R1 : IDLE;
      R1:      w_next = (SBOX_REG != 0) ? R1S : R2;
      R1S:     w_next = R2;
      R2:      w_next = (SBOX_REG != 0) ? R2S : DONE;
      R2S:     w_next = DONE;
      DONE:    w_next = w_out_hs ? (w_acc ? R1 : IDLE) : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_ka    <= '0;
      r_kb    <= '0;
      r_p4    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == R2_END) | (r_valid & ~i_ready);
      if (w_acc) begin
        r_blk <= ip(i_data);
        r_ka  <= i_mode ? i_k2 : i_k1;
        r_kb  <= i_mode ? i_k1 : i_k2;
      end
      if (r_state == R1 || r_state == R2) r_p4 <= w_p4;
      if (r_state == R1_END) r_blk <= {r_blk[3:0], w_l};
      if (r_state == R2_END) r_data <= ip_inv({w_l, r_blk[3:0]});
    end
  end
`ifdef SDES_BLK_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (w_out_hs) r_cnt <= r_cnt + 16'd1;
  end
  assign o_blk_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_sdes_crypt_core.sv
// tb_sdes_crypt_core: directed checks of sdes_crypt_core with SBOX_REG 0 (u0) and 1 (u1)
module tb_sdes_crypt_core;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0, mode = 1'b0, rdy_in = 1'b0, sel = 1'b0;
  logic [7:0] data = '0, k1 = '0, k2 = '0;
  logic rdy0, rdy1, ov0, ov1;
  logic [7:0] od0, od1;
  logic ordy, ovalid;
  logic [7:0] odata;
  int n_chk = 0, n_fail = 0;
`ifdef SDES_BLK_CNT_EN
  logic [15:0] cnt0, cnt1;
  int e0 = 0;
`endif
  always #5 clk = ~clk;
  assign ordy   = sel ? rdy1 : rdy0;
  assign ovalid = sel ? ov1 : ov0;
  assign odata  = sel ? od1 : od0;
  sdes_crypt_core #(.SBOX_REG(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & ~sel), .o_ready(rdy0), .i_mode(mode),
    .i_data(data), .i_k1(k1), .i_k2(k2), .o_valid(ov0), .i_ready(rdy_in), .o_data(od0)
`ifdef SDES_BLK_CNT_EN
    , .o_blk_cnt(cnt0)
`endif
  );
  sdes_crypt_core #(.SBOX_REG(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & sel), .o_ready(rdy1), .i_mode(mode),
    .i_data(data), .i_k1(k1), .i_k2(k2), .o_valid(ov1), .i_ready(rdy_in), .o_data(od1)
`ifdef SDES_BLK_CNT_EN
    , .o_blk_cnt(cnt1)
`endif
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Accept one block, disturb inputs while busy, then wait for the result and check latency/data.
  task automatic run(input string tag, input logic m, input logic [7:0] d, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] exp, input int lat);
    int n;
    @(negedge clk);
    chk({tag, " ready"}, 16'(ordy), 16'd1);
    valid = 1'b1; mode = m; data = d; k1 = a; k2 = b;
    @(negedge clk);
    mode = ~m; data = ~d; k1 = ~a; k2 = ~b;
    n = 1;
    @(negedge clk);
    valid = 1'b0;
    n = 2;
    while (!ovalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 16'(n), 16'(lat));
    chk({tag, " data"}, 16'(odata), 16'(exp));
  endtask
  task automatic consume(input string tag);
    @(negedge clk);
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
`ifdef SDES_BLK_CNT_EN
    if (!sel) e0++;
`endif
    chk({tag, " valid drop"}, 16'(ovalid), 16'd0);
    chk({tag, " ready back"}, 16'(ordy), 16'd1);
  endtask
  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    chk("reset ready", 16'(ordy), 16'd0);
    chk("reset valid", 16'(ovalid), 16'd0);
    chk("reset data", 16'(odata), 16'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release ready", 16'(ordy), 16'd1);
    sel = 1'b0;
    run("enc0", 1'b0, 8'b10010111, 8'b10100100, 8'b01000011, 8'b00111000, 3);
    consume("enc0");
    run("dec0", 1'b1, 8'b00111000, 8'b10100100, 8'b01000011, 8'b10010111, 3);
    consume("dec0");
    sel = 1'b1;
    run("enc1", 1'b0, 8'b10010111, 8'b10100100, 8'b01000011, 8'b00111000, 5);
    consume("enc1");
    run("dec1", 1'b1, 8'b00111000, 8'b10100100, 8'b01000011, 8'b10010111, 5);
    consume("dec1");
    sel = 1'b0;
    run("zero", 1'b0, 8'h00, 8'h00, 8'h00, 8'b11110000, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = i[0];
      data = 8'h55;
    end
    valid = 1'b0;
    chk("hold data", 16'(odata), 16'hF0);
    chk("hold ready", 16'(ordy), 16'd0);
    chk("hold valid", 16'(ovalid), 16'd1);
    consume("hold");
    run("b2b first", 1'b0, 8'b10010111, 8'b10100100, 8'b01000011, 8'b00111000, 3);
    rdy_in = 1'b1; valid = 1'b1; mode = 1'b0; data = 8'h00; k1 = 8'h00; k2 = 8'h00;
    #1 chk("b2b ready", 16'(ordy), 16'd1);
    @(negedge clk);
    rdy_in = 1'b0; valid = 1'b0;
`ifdef SDES_BLK_CNT_EN
    e0++;
`endif
    chk("b2b taken", 16'(ovalid), 16'd0);
    chk("b2b busy", 16'(ordy), 16'd0);
    n = 1;
    while (!ovalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b latency", 16'(n), 16'd3);
    chk("b2b data", 16'(odata), 16'hF0);
    consume("b2b");
`ifdef SDES_BLK_CNT_EN
    chk("blk cnt", cnt0, 16'(e0));
`endif
    @(negedge clk);
    valid = 1'b1; mode = 1'b0; data = 8'b10010111; k1 = 8'b10100100; k2 = 8'b01000011;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 16'(ovalid), 16'd0);
    chk("midrst data", 16'(odata), 16'h00);
    chk("midrst ready", 16'(ordy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SDES_BLK_CNT_EN
    e0 = 0;
`endif
    #1 chk("midrst release", 16'(ordy), 16'd1);
    repeat (3) @(negedge clk);
    chk("midrst discarded", 16'(ovalid), 16'd0);
    run("fresh", 1'b1, 8'b00111000, 8'b10100100, 8'b01000011, 8'b10010111, 3);
    consume("fresh");
`ifdef SDES_BLK_CNT_EN
    chk("blk cnt after reset", cnt0, 16'(e0));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
